// File: rtl/wordle_round_ctrl.sv
// -----------------------------------------------------------------------------
// wordle_round_ctrl
//
// Round sequencer for the Wordle game. Debounces the active-low enter button,
// steps the letter-entry slot, and issues the one-cycle strobes that drive the
// external letter registers, comparator and feedback LEDs. It also counts
// failed attempts up to a win or a loss.
//
// Parameters
//   WORD_LEN      letters per guess (slot range 0..WORD_LEN-1)
//   MAX_TRIES     failed guesses allowed before LOSE
//   DEBOUNCE_CYC  consecutive differing synchronized samples to accept a level
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous, active-low reset
//   enter       in   raw pushbutton, asynchronous, 0 = pressed
//   match_all   in   comparator result, sampled in the EVAL cycle
//   clr         out  strobe: clear guess registers and feedback LEDs
//   load_en     out  strobe: capture switch letter into slot `slot`
//   slot        out  current entry slot index
//   cmp_go      out  strobe: start compare of the captured word
//   led_update  out  strobe: latch per-letter match LEDs
//   tries       out  completed failed guesses (saturates at MAX_TRIES)
//   phase       out  FSM state, doubles as the debug view of the sequencer
//
// Handshake: there is no back-pressure. Every strobe is a single-cycle pulse
// that the datapath must act on in the cycle it is high; match_all must be
// valid in the cycle after cmp_go (the EVAL cycle).
// -----------------------------------------------------------------------------
module wordle_round_ctrl #(
    parameter int WORD_LEN     = 4,
    parameter int MAX_TRIES    = 5,
    parameter int DEBOUNCE_CYC = 4,
    localparam int SLOT_W      = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1,
    localparam int TRY_W       = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  logic              match_all,
    output logic              clr,
    output logic              load_en,
    output logic [SLOT_W-1:0] slot,
    output logic              cmp_go,
    output logic              led_update,
    output logic [TRY_W-1:0]  tries,
    output logic [2:0]        phase
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_LEN - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_ENTRY    = 3'd1,
        PH_CHECK    = 3'd2,
        PH_EVAL     = 3'd3,
        PH_FEEDBACK = 3'd4,
        PH_WIN      = 3'd5,
        PH_LOSE     = 3'd6
    } phase_e;

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic             sync1_q, sync2_q;
    logic             acc_q;     // accepted (debounced) level, 1 = released
    logic             armed_q;   // a stable release has been seen since reset
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // The synchronizer resets to "pressed" so the two cycles it takes to fill
    // after reset can never count toward arming. Until armed, the counter
    // measures a stable release; a button held through reset therefore keeps
    // the block disarmed and produces no press until it is let go.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= enter;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (!armed_q) begin
                if (cnt_q == CNT_FULL) begin
                    armed_q <= 1'b1;
                    cnt_q   <= '0;
                end else if (sync2_q) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    cnt_q <= '0;
                end
            end else if (cnt_q == CNT_FULL) begin
                // Level change accepted; a 1->0 flip is a press.
                acc_q   <= ~acc_q;
                cnt_q   <= '0;
                press_q <= acc_q;
            end else if (sync2_q != acc_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round FSM
    // ------------------------------------------------------------------
    phase_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic              clr_q, clr_d;
    logic              load_q, load_d;
    logic              cmp_q, cmp_d;
    logic              led_q, led_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PH_IDLE;
            slot_q  <= '0;
            tries_q <= '0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            cmp_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tries_q <= tries_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            cmp_q   <= cmp_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        tries_d = tries_q;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        cmp_d   = 1'b0;
        led_d   = 1'b0;
        unique case (state_q)
            PH_IDLE: begin
                if (press_q) begin
                    state_d = PH_ENTRY;
                    clr_d   = 1'b1;
                    slot_d  = '0;
                    tries_d = '0;
                end
            end
            PH_ENTRY: begin
                // slot advances one cycle after load_en so the load_en cycle
                // still shows the slot being written.
                if (load_q) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = PH_CHECK;
                        slot_d  = '0;
                        cmp_d   = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else if (press_q) begin
                    load_d = 1'b1;
                end
            end
            PH_CHECK: begin
                state_d = PH_EVAL;
            end
            PH_EVAL: begin
                if (match_all) begin
                    state_d = PH_WIN;
                end else if (tries_q == TRY_LAST) begin
                    state_d = PH_LOSE;
                    tries_d = tries_q + TRY_W'(1);
                end else begin
                    state_d = PH_FEEDBACK;
                    tries_d = tries_q + TRY_W'(1);
                    led_d   = 1'b1;
                end
            end
            PH_FEEDBACK: begin
                if (press_q) begin
                    state_d = PH_ENTRY;
                    slot_d  = '0;
                end
            end
            PH_WIN, PH_LOSE: begin
                if (press_q) begin
                    state_d = PH_IDLE;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    assign clr        = clr_q;
    assign load_en    = load_q;
    assign cmp_go     = cmp_q;
    assign led_update = led_q;
    assign slot       = slot_q;
    assign tries      = tries_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_wordle_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wordle_round_ctrl
//
// Directed bench for wordle_round_ctrl. Stimulus pushes the expected strobe
// events (strobe kind, slot, tries, phase) into exp_q; a negedge monitor pops
// and compares whenever any strobe is high. Settled state is checked directly
// after each step.
// -----------------------------------------------------------------------------
module tb_wordle_round_ctrl;

    localparam int W = 12;
    localparam logic [3:0] S_CLR  = 4'b1000;
    localparam logic [3:0] S_LOAD = 4'b0100;
    localparam logic [3:0] S_CMP  = 4'b0010;
    localparam logic [3:0] S_LED  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter = 1'b1;
    logic       match_all = 1'b0;
    logic       clr, load_en, cmp_go, led_update;
    logic [1:0] slot;
    logic [2:0] tries;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    wordle_round_ctrl #(
        .WORD_LEN(4),
        .MAX_TRIES(5),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enter(enter),
        .match_all(match_all),
        .clr(clr),
        .load_en(load_en),
        .slot(slot),
        .cmp_go(cmp_go),
        .led_update(led_update),
        .tries(tries),
        .phase(phase)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] s, input int sl,
                                        input int tr, input int ph);
        logic [1:0] sl2;
        logic [2:0] tr3, ph3;
        sl2 = 2'(sl);
        tr3 = 3'(tr);
        ph3 = 3'(ph);
        return {s, sl2, tr3, ph3};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic state_chk(input string name, input int ph, input int sl,
                             input int tr);
        check({name, "_phase"}, int'(phase), ph);
        check({name, "_slot"}, int'(slot), sl);
        check({name, "_tries"}, int'(tries), tr);
    endtask

    // ---------------- driver ----------------
    task automatic press_n(input int low, input int high);
        enter = 1'b0;
        repeat (low) @(negedge clk);
        enter = 1'b1;
        repeat (high) @(negedge clk);
    endtask

    task automatic press();
        press_n(8, 8);
    endtask

    // Expected events for four letters starting from slot 0 plus the result.
    task automatic push_round(input int tries_before, input logic win);
        for (int s = 0; s < 4; s++) exp_q.push_back(ev(S_LOAD, s, tries_before, 1));
        exp_q.push_back(ev(S_CMP, 0, tries_before, 2));
        if (!win && tries_before + 1 < 5)
            exp_q.push_back(ev(S_LED, 0, tries_before + 1, 4));
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [3:0] prev_s = 4'b0;
    logic [1:0] prev_slot = 2'b0;

    always @(negedge clk) begin
        logic [3:0]   s;
        logic [W-1:0] obs, e;
        s = {clr, load_en, cmp_go, led_update};
        if (rst_n) begin
            if (prev_s == S_LOAD && prev_slot == 2'd3)
                check("cmp_go_after_last_load", int'(cmp_go), 1);
            if (prev_s == S_CMP)
                check("eval_after_cmp_go", int'(phase), 3);
            if (s != 4'b0) begin
                check("strobe_onehot", $countones(s), 1);
                check("strobe_not_repeated", int'((s & prev_s) != 4'b0), 0);
                obs = {s, slot, tries, phase};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %h expected none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL strobe_event: got %h expected %h", obs, e);
                    end
                end
            end
        end
        prev_s    = rst_n ? s : 4'b0;
        prev_slot = slot;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;

        // Reset with the button held low.
        rst_n = 1'b0;
        enter = 1'b0;
        repeat (5) @(negedge clk);
        state_chk("reset", 0, 0, 0);
        check("reset_strobes", int'({clr, load_en, cmp_go, led_update}), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        state_chk("held_through_reset", 0, 0, 0);
        enter = 1'b1;
        repeat (10) @(negedge clk);

        // First clean press: clr 8 samples after the first low sample.
        exp_q.push_back(ev(S_CLR, 0, 0, 1));
        enter = 1'b0;
        k = 0;
        while (!clr && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("press_latency", k, 8);
        enter = 1'b1;
        repeat (10) @(negedge clk);
        drain("first_press");
        state_chk("entry", 1, 0, 0);

        // Winning round.
        match_all = 1'b1;
        push_round(0, 1'b1);
        repeat (4) press();
        drain("win_round");
        state_chk("win", 5, 0, 0);
        press();
        check("win_to_idle", int'(phase), 0);

        // Five failing rounds.
        match_all = 1'b0;
        exp_q.push_back(ev(S_CLR, 0, 0, 1));
        press();
        for (int r = 0; r < 5; r++) begin
            if (r > 0) begin
                press();
                state_chk("feedback_to_entry", 1, 0, r);
            end
            push_round(r, 1'b0);
            repeat (4) press();
            drain("lose_round");
            if (r < 4) state_chk("feedback", 4, 0, r + 1);
            else       state_chk("lose", 6, 0, 5);
        end
        press();
        check("lose_to_idle", int'(phase), 0);

        // Bounce: 1-cycle pulses must not load.
        exp_q.push_back(ev(S_CLR, 0, 0, 1));
        press();
        enter = 1'b0; @(negedge clk);
        enter = 1'b1; @(negedge clk);
        enter = 1'b0; @(negedge clk);
        enter = 1'b1;
        repeat (12) @(negedge clk);
        state_chk("bounce_ignored", 1, 0, 0);
        exp_q.push_back(ev(S_LOAD, 0, 0, 1));
        press_n(6, 10);
        drain("bounce_then_stable");
        check("slot_after_stable", int'(slot), 1);

        // Press held through CHECK/EVAL.
        exp_q.push_back(ev(S_LOAD, 1, 0, 1));
        exp_q.push_back(ev(S_LOAD, 2, 0, 1));
        repeat (2) press();
        exp_q.push_back(ev(S_LOAD, 3, 0, 1));
        exp_q.push_back(ev(S_CMP, 0, 0, 2));
        exp_q.push_back(ev(S_LED, 0, 1, 4));
        press_n(40, 10);
        drain("held_press");
        state_chk("held_feedback", 4, 0, 1);
        press();
        state_chk("held_new_press", 1, 0, 1);

        // Reach ENTRY with slot=2, tries=3, then reset for one cycle.
        for (int r = 1; r < 3; r++) begin
            push_round(r, 1'b0);
            repeat (4) press();
            drain("pre_reset_round");
            press();
        end
        exp_q.push_back(ev(S_LOAD, 0, 3, 1));
        exp_q.push_back(ev(S_LOAD, 1, 3, 1));
        repeat (2) press();
        drain("pre_reset_letters");
        state_chk("pre_reset", 1, 2, 3);
        rst_n = 1'b0;
        @(negedge clk);
        state_chk("mid_reset", 0, 0, 0);
        check("mid_reset_strobes", int'({clr, load_en, cmp_go, led_update}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_idle", int'(phase), 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
